program_write_arbiter: RTL

// - Shares the SRAM controller's single program-write port (program_x/y/data/write) among
//   N_REQ drawing engines (sprite, bullet, text overlay, HUD) using round-robin with bursts.
// - Aligns every transfer to the controller's program-write sampling slots (every 2nd cycle).
// - Tracks frame flips from frame_clk. Drops grants at each flip so no pixel lands in the

---
 rtl/program_write_arbiter_pkg.sv | 20 ++
 rtl/program_write_arbiter_rr_pick.sv | 32 +++
 rtl/program_write_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/program_write_arbiter_pkg.sv
// Shared types for the program-write arbiter:
// arbiter states, screen size and the pixel bundle.
package boxhead_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_FLUSH
  } arb_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] data;
  } pixel_t;

endpackage

// File: rtl/program_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
// Scans valid_i from ptr_i upward with wrap-around.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  sel_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // first valid requester at or after the pointer wins
  always_comb begin
    int j;
    sel_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        sel_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/program_write_arbiter.sv
// program_write_arbiter: round-robin burst arbiter for the SRAM
// program-write port, slot-aligned and frame-flip aware.
module program_write_arbiter
  import boxhead_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 19
) (
  input  logic                sram_clk,
  input  logic                reset,
  input  logic                frame_clk,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*10-1:0] req_x,
  input  logic [N_REQ*10-1:0] req_y,
  input  logic [N_REQ*16-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                frame_start,
  output logic [9:0]          program_x,
  output logic [9:0]          program_y,
  output logic [15:0]         program_data,
  output logic                program_write,
  output logic                frame_overrun,
  output logic [CNT_W-1:0]    frame_pixels
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = 9;

  logic             phase_q;
  arb_state_t       state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    own, pick_idx;
  logic [BW-1:0]    burst_q, burst_d;
  logic [BW-1:0]    base, burst_nxt;
  logic [N_REQ-1:0] pick_sel, ready;
  logic             pick_any, active, xfer, rel;
  pixel_t           pix_q, pix_d;
  logic             wr_q, wr_d;
  logic             fclk_s1_q, fclk_s2_q, fclk_s3_q;
  logic             fs_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc, fpix_q;
  logic             ovr_q;
  int               oi;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .sel_o   (pick_sel),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // arbiter next state, ready strobes and burst accounting
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    own     = owner_q;
    active  = 1'b0;
    base    = burst_q;
    unique case (state_q)
      ARB_IDLE: begin
        own    = pick_idx;
        active = phase_q & pick_any & ~reset;
        base   = '0;
      end
      ARB_GRANT: active = 1'b1;
      default:   active = 1'b0;
    endcase
    ready = '0;
    if (!reset && phase_q) begin
      if (state_q == ARB_IDLE)
        ready = pick_sel;
      else if (state_q == ARB_GRANT && req_valid[owner_q])
        ready[owner_q] = 1'b1;
    end
    xfer      = |ready;
    burst_nxt = base + BW'(xfer);
    rel = (xfer & req_last[own])
        | (burst_nxt >= BW'(MAX_BURST))
        | (phase_q & ~req_valid[own]);
    if (active) begin
      if (rel) begin
        ptr_d   = (own == PW'(N_REQ - 1)) ? '0 : own + PW'(1);
        state_d = ARB_IDLE;
        burst_d = '0;
      end else begin
        state_d = ARB_GRANT;
        owner_d = own;
        burst_d = burst_nxt;
      end
    end
    if (state_q == ARB_FLUSH && phase_q) state_d = ARB_IDLE;
    // a flip overrides everything; an in-flight transfer still lands
    if (fs_q) begin
      state_d = ARB_FLUSH;
      burst_d = '0;
    end
  end

  assign oi = int'(own);

  // program-port next values, only moved at the end of phase 1
  always_comb begin
    pix_d = pix_q;
    wr_d  = wr_q;
    if (phase_q) begin
      wr_d = xfer;
      if (xfer) begin
        pix_d.x    = req_x[oi*10 +: 10];
        pix_d.y    = req_y[oi*10 +: 10];
        pix_d.data = req_data[oi*16 +: 16];
      end
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(xfer);

  // slot phase and arbiter registers
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      phase_q <= ~phase_q;
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // program-write port registers
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      pix_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      wr_q  <= wr_d;
    end
  end

  // frame_clk synchroniser and registered rising-edge pulse
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      fclk_s1_q <= 1'b0;
      fclk_s2_q <= 1'b0;
      fclk_s3_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      fclk_s1_q <= frame_clk;
      fclk_s2_q <= fclk_s1_q;
      fclk_s3_q <= fclk_s2_q;
      fs_q      <= fclk_s2_q & ~fclk_s3_q;
    end
  end

  // per-frame pixel count and overrun flag
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      fpix_q <= '0;
      ovr_q  <= 1'b0;
    end else if (fs_q) begin
      fpix_q <= cnt_inc;
      cnt_q  <= '0;
      ovr_q  <= |req_valid;
    end else begin
      cnt_q  <= cnt_inc;
    end
  end

  assign req_ready     = ready;
  assign frame_start   = fs_q;
  assign program_x     = pix_q.x;
  assign program_y     = pix_q.y;
  assign program_data  = pix_q.data;
  assign program_write = wr_q;
  assign frame_overrun = ovr_q;
  assign frame_pixels  = fpix_q;

endmodule
